pcm_sample_streamer: RTL and testbench

- Upstream feeder for the PCM/PWM player stage.
- On a start command it walks a contiguous region of the synchronous sound ROM (start address, sample count).
- Absorbs ROM read latency with credit-based prefetch into a small FIFO.
- Presents 8-bit samples on a valid/ready interface; the downstream player pulls one sample per PWM period.
- Supports one-shot and looped playback, plus abort.

---
 rtl/pcm_sample_streamer_if.sv | 8 +
 rtl/pcm_sample_streamer.sv | 124 ++++++++++++
 tb/tb_pcm_sample_streamer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/pcm_sample_streamer_if.sv
// pcm_sample_streamer_if: valid/ready sample stream from the streamer to the PCM/PWM player.
interface pcm_sample_streamer_if #(parameter int DATA_W = 8);
    logic [DATA_W-1:0] sample_out;
    logic              sample_valid;
    logic              sample_ready;
    modport master (output sample_out, sample_valid, input sample_ready);
    modport slave  (input sample_out, sample_valid, output sample_ready);
endinterface

// File: rtl/pcm_sample_streamer.sv
// pcm_sample_streamer: walks a sound ROM region with credit-based prefetch into a FWFT sample FIFO.
// Define PCM_STREAMER_UNDERRUN_EN to add the underrun_cnt_o consumer-starvation counter.
module pcm_sample_streamer #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int ROM_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start_i,
    input  logic [ADDR_W-1:0]     start_addr_i,
    input  logic [ADDR_W:0]       length_i,
    input  logic                  loop_en_i,
    input  logic                  stop_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_W-1:0]     rom_a_o,
    input  logic [DATA_W-1:0]     rom_d_i,
`ifdef PCM_STREAMER_UNDERRUN_EN
    output logic [15:0]           underrun_cnt_o,
`endif
    pcm_sample_streamer_if.master smp
);
    localparam int PW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d, base_q, base_d, rom_a_q, rom_a_d, src_addr;
    logic [ADDR_W:0]     rem_q, rem_d, len_q, len_d, src_rem;
    logic                loop_q, loop_d, done_q, done_d;
    logic [ROM_LAT:0]    tag_q, tag_d;
    logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0]   hold_q, hold_d;
    logic [PW-1:0]       wr_q, rd_q;
    logic [PW:0]         cnt_q;
    logic                accept, abort, issue, push, pop, drained, valid;

    assign valid            = cnt_q != '0;
    assign smp.sample_valid = valid;
    assign smp.sample_out   = valid ? mem_q[rd_q] : hold_q;
    assign busy_o           = state_q != IDLE;
    assign done_o           = done_q;
    assign rom_a_o          = rom_a_q;

    // The first read issues on the accepting edge; credits count FIFO entries plus reads in flight.
    always_comb begin
        accept   = state_q == IDLE && start_i && !stop_i;
        abort    = state_q != IDLE && stop_i;
        base_d   = accept ? start_addr_i : base_q;
        len_d    = accept ? length_i : len_q;
        loop_d   = accept ? loop_en_i : loop_q;
        src_addr = accept ? start_addr_i : addr_q;
        src_rem  = accept ? length_i : rem_q;
        issue    = (accept || (state_q == FETCH && !stop_i)) && src_rem != '0
                   && int'(cnt_q) + $countones(tag_q) < FIFO_DEPTH;
        tag_d    = {tag_q[ROM_LAT-1:0], issue};
        push     = tag_q[ROM_LAT];
        pop      = valid && smp.sample_ready;
        drained  = cnt_q == '0 && tag_q == '0;
        rom_a_d  = issue ? src_addr : rom_a_q;
        addr_d   = issue ? src_addr + 1'b1 : addr_q;
        rem_d    = issue ? src_rem - 1'b1 : rem_q;
        state_d  = abort ? IDLE
                 : accept ? (length_i != '0 ? FETCH : IDLE)
                 : (state_q == DRAIN && drained) ? IDLE : state_q;
        if (issue && rem_d == '0) begin
            addr_d  = loop_d ? base_d : addr_d;
            rem_d   = loop_d ? len_d : rem_d;
            state_d = loop_d ? state_d : DRAIN;
        end
        done_d   = !abort && ((accept && length_i == '0) || (state_q == DRAIN && drained));
        hold_d   = abort ? '0 : pop ? mem_q[rd_q] : hold_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            base_q  <= '0;
            rom_a_q <= '0;
            rem_q   <= '0;
            len_q   <= '0;
            loop_q  <= 1'b0;
            done_q  <= 1'b0;
            tag_q   <= '0;
            hold_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            base_q  <= base_d;
            rom_a_q <= rom_a_d;
            rem_q   <= rem_d;
            len_q   <= len_d;
            loop_q  <= loop_d;
            done_q  <= done_d;
            hold_q  <= hold_d;
            if (abort) begin
                tag_q <= '0;
                wr_q  <= '0;
                rd_q  <= '0;
                cnt_q <= '0;
            end else begin
                tag_q <= tag_d;
                if (push) mem_q[wr_q] <= rom_d_i;
                wr_q  <= wr_q + {{(PW-1){1'b0}}, push};
                rd_q  <= rd_q + {{(PW-1){1'b0}}, pop};
                cnt_q <= cnt_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
            end
        end
    end

`ifdef PCM_STREAMER_UNDERRUN_EN
    logic [15:0] urun_q;
    always_ff @(posedge clk) begin
        if (!reset_n || accept) urun_q <= '0;
        else if (busy_o && smp.sample_ready && !valid && urun_q != 16'hFFFF) urun_q <= urun_q + 1'b1;
    end
    assign underrun_cnt_o = urun_q;
`endif
endmodule

// File: tb/tb_pcm_sample_streamer.sv
// tb_pcm_sample_streamer: directed self-checking bench for pcm_sample_streamer with ROM[a] = a[7:0].
`timescale 1ns/1ps
module tb_pcm_sample_streamer;
    localparam int ADDR_W = 11, DATA_W = 8, FIFO_DEPTH = 4;
    logic              clk = 1'b0, reset_n = 1'b0, start_i = 1'b0, loop_en_i = 1'b0, stop_i = 1'b0;
    logic [ADDR_W-1:0] start_addr_i = '0;
    logic [ADDR_W-1:0] rom_a_o;
    logic [ADDR_W:0]   length_i = '0;
    logic              busy_o, done_o;
    logic [DATA_W-1:0] rom_d_i = '0;
`ifdef PCM_STREAMER_UNDERRUN_EN
    logic [15:0]       underrun_cnt_o;
`endif
    int n_chk = 0, n_err = 0, done_cnt = 0, max_cnt = 0, cyc = 0, d0 = 0;
    logic [7:0] got[$];

    pcm_sample_streamer_if #(.DATA_W(DATA_W)) smp ();

    pcm_sample_streamer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .ROM_LAT(1)) dut (
        .clk(clk), .reset_n(reset_n), .start_i(start_i), .start_addr_i(start_addr_i),
        .length_i(length_i), .loop_en_i(loop_en_i), .stop_i(stop_i), .busy_o(busy_o),
        .done_o(done_o), .rom_a_o(rom_a_o), .rom_d_i(rom_d_i),
`ifdef PCM_STREAMER_UNDERRUN_EN
        .underrun_cnt_o(underrun_cnt_o),
`endif
        .smp(smp)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rom_d_i <= rom_a_o[7:0];
    always @(negedge clk) begin
        if (reset_n && smp.sample_valid && smp.sample_ready) got.push_back(smp.sample_out);
        if (done_o) done_cnt++;
        if (int'(dut.cnt_q) > max_cnt) max_cnt = int'(dut.cnt_q);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step(input int k = 1);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_cmd(input logic [ADDR_W-1:0] a, input logic [ADDR_W:0] l, input logic lp);
        start_addr_i = a;
        length_i     = l;
        loop_en_i    = lp;
        start_i      = 1'b1;
        step();
        start_i      = 1'b0;
    endtask

    task automatic run_done(input int budget, input int period, output int cycles);
        cycles = 0;
        while (!done_o && cycles < budget) begin
            smp.sample_ready = (cycles % period) == 0;
            step();
            cycles++;
        end
        if (!done_o) check("done_timeout", 32'(done_o), 1);
        smp.sample_ready = 1'b1;
    endtask

    task automatic check_seq(input string tag, input int base, input int len);
        check({tag, "_count"}, 32'(got.size()), 32'(len));
        for (int i = 0; i < len && i < got.size(); i++)
            check({tag, "_data"}, 32'(got[i]), 32'((base + i) & 255));
    endtask

    initial begin
        smp.sample_ready = 1'b0;
        step(2);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_done", 32'(done_o), 0);
        check("rst_valid", 32'(smp.sample_valid), 0);
        check("rst_out", 32'(smp.sample_out), 0);
        check("rst_rom_a", 32'(rom_a_o), 0);
        reset_n = 1'b1;
        step();

        // one-shot: first sample two cycles after the accepting edge, done nine cycles later
        got.delete();
        done_cnt = 0;
        smp.sample_ready = 1'b1;
        start_cmd(11'h010, 12'd8, 1'b0);
        check("os_busy", 32'(busy_o), 1);
        step(2);
        check("os_first_valid", 32'(smp.sample_valid), 1);
        check("os_first_out", 32'(smp.sample_out), 32'h10);
`ifdef PCM_STREAMER_UNDERRUN_EN
        check("urun_first", 32'(underrun_cnt_o), 2);
`endif
        run_done(40, 1, cyc);
        check("os_latency", 32'(cyc), 9);
        check("os_busy_at_done", 32'(busy_o), 0);
        step();
        check("os_done_once", 32'(done_cnt), 1);
        check("os_done_low", 32'(done_o), 0);
        check("os_valid_low", 32'(smp.sample_valid), 0);
        check_seq("os", 'h10, 8);

        // length zero
        d0 = done_cnt;
        start_cmd(11'h123, 12'd0, 1'b0);
        check("len0_done", 32'(done_o), 1);
        check("len0_busy", 32'(busy_o), 0);
`ifdef PCM_STREAMER_UNDERRUN_EN
        check("urun_cleared", 32'(underrun_cnt_o), 0);
`endif
        step();
        check("len0_done_pulse", 32'(done_cnt - d0), 1);
        check("len0_busy_after", 32'(busy_o), 0);

        // backpressure 1-in-5
        got.delete();
        done_cnt = 0;
        start_cmd(11'h100, 12'd16, 1'b0);
        max_cnt = 0;
        run_done(300, 5, cyc);
        step();
        check_seq("bp", 0, 16);
        check("bp_fifo_peak", 32'(max_cnt), FIFO_DEPTH);
        check("bp_done_once", 32'(done_cnt), 1);

        // wrap plus loop, then stop
        got.delete();
        done_cnt = 0;
        start_cmd(11'h7FE, 12'd3, 1'b1);
        for (int k = 0; k < 40 && got.size() < 12; k++) step();
        check("loop_enough", 32'(got.size() >= 12), 1);
        for (int i = 0; i < 12 && i < got.size(); i++)
            check("loop_data", 32'(got[i]), 32'((254 + i % 3) & 255));
        check("loop_busy", 32'(busy_o), 1);
        stop_i = 1'b1;
        step();
        stop_i = 1'b0;
        check("stop_busy", 32'(busy_o), 0);
        check("stop_valid", 32'(smp.sample_valid), 0);
        step(3);
        check("loop_no_done", 32'(done_cnt), 0);

        // start and stop together
        got.delete();
        start_addr_i = 11'h200;
        length_i     = 12'd5;
        start_i      = 1'b1;
        stop_i       = 1'b1;
        step();
        start_i      = 1'b0;
        stop_i       = 1'b0;
        check("ss_busy", 32'(busy_o), 0);
        step(4);
        check("ss_no_samples", 32'(got.size()), 0);
        check("ss_no_done", 32'(done_cnt), 0);

        // start while busy
        got.delete();
        start_cmd(11'h020, 12'd6, 1'b0);
        step();
        start_cmd(11'h300, 12'd2, 1'b1);
        run_done(40, 1, cyc);
        step();
        check_seq("sb", 'h20, 6);
        check("sb_done_once", 32'(done_cnt), 1);

        // reset mid-run with a non-empty FIFO
        got.delete();
        done_cnt = 0;
        smp.sample_ready = 1'b0;
        start_cmd(11'h040, 12'd16, 1'b0);
        step(6);
        check("mr_pre_valid", 32'(smp.sample_valid), 1);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check("mr_busy", 32'(busy_o), 0);
        check("mr_valid", 32'(smp.sample_valid), 0);
        check("mr_out", 32'(smp.sample_out), 0);
        check("mr_rom_a", 32'(rom_a_o), 0);
        check("mr_done", 32'(done_o), 0);
        smp.sample_ready = 1'b1;
        start_cmd(11'h050, 12'd4, 1'b0);
        run_done(40, 1, cyc);
        step();
        check_seq("mr", 'h50, 4);
        check("mr_done_once", 32'(done_cnt), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
